// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared sequencer states, constants and helpers for the SPI byte bridge
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RX   = 2'd2,
        ST_WAIT_DONE = 2'd3
    } seq_state_t;

    // Byte returned when the host reads an empty rx FIFO.
    localparam logic [7:0] EMPTY_READ_BYTE = 8'hFF;

    localparam int DEFAULT_TIMEOUT    = 255;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte-wide FIFO with occupancy level, used for both tx and rx buffering
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write strobe and byte
//   pop               : read strobe; head advances only when non-empty
//   head              : oldest stored byte (valid when empty=0)
//   full, empty, level: occupancy status, level in 0..DEPTH
module byte_fifo
    import bridge_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [7:0]                      push_data,
    input  logic                            pop,
    output logic [7:0]                      head,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the same-cycle pop frees a slot.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// rtl/spi_byte_sequencer.sv - buffers host bytes, feeds them one at a time to an SPI master, queues replies
//   clk, rst                    : clock, asynchronous active-high reset
//   wr_data, wr_valid           : host byte push into the tx FIFO
//   rd_req, rd_data, rd_valid   : host pop from the rx FIFO, answered one cycle later
//   tx_data, tx_valid, tx_ready : byte handoff to the SPI master
//   rx_data, rx_valid, spi_busy : reply byte and activity from the SPI master
//   clr_err                     : clears the sticky flags
//   tx_ovf, rx_ovf, timeout_err : sticky error flags
//   tx_level, rx_level          : FIFO occupancy
module spi_byte_sequencer
    import bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           wr_data,
    input  logic                                 wr_valid,
    input  logic                                 rd_req,
    output logic [7:0]                           rd_data,
    output logic                                 rd_valid,
    output logic [7:0]                           tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    input  logic [7:0]                           rx_data,
    input  logic                                 rx_valid,
    input  logic                                 spi_busy,
    input  logic                                 clr_err,
    output logic                                 tx_ovf,
    output logic                                 rx_ovf,
    output logic                                 timeout_err,
    output logic [level_width(FIFO_DEPTH)-1:0]   tx_level,
    output logic [level_width(FIFO_DEPTH)-1:0]   rx_level
);

    localparam int               CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             tx_valid_next;
    logic             tx_pop;
    logic             rx_push_req;
    logic             timeout_evt;
    logic             cnt_expired;

    logic [7:0]       tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_ovf_evt;

    logic [7:0]       rx_head;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_ovf_evt;

    // A host byte arriving at a full tx FIFO is lost even if the sequencer pops this cycle.
    assign tx_push    = wr_valid && !tx_full;
    assign tx_ovf_evt = wr_valid && tx_full;

    // The rx side lets a same-cycle host read make room for the reply byte.
    assign rx_push    = rx_push_req && (!rx_full || rd_req);
    assign rx_ovf_evt = rx_push_req && rx_full && !rd_req;

    assign cnt_expired = (cnt == TIMEOUT_LAST);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (wr_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rd_req),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            tx_valid <= tx_valid_next;
            if (tx_pop) begin
                tx_data <= tx_head;
            end
        end
    end

    // The wait counter restarts on every state change, so REQ and WAIT_RX each
    // get a full TIMEOUT-cycle budget. A handshake on the last budget cycle wins.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        tx_valid_next = tx_valid;
        tx_pop        = 1'b0;
        rx_push_req   = 1'b0;
        timeout_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tx_empty && !spi_busy) begin
                    tx_pop        = 1'b1;
                    tx_valid_next = 1'b1;
                    cnt_next      = '0;
                    state_next    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (tx_ready) begin
                    tx_valid_next = 1'b0;
                    cnt_next      = '0;
                    state_next    = ST_WAIT_RX;
                end else if (cnt_expired) begin
                    timeout_evt   = 1'b1;
                    tx_valid_next = 1'b0;
                    cnt_next      = '0;
                    state_next    = ST_WAIT_DONE;
                end else begin
                    cnt_next      = cnt + 1'b1;
                end
            end
            ST_WAIT_RX: begin
                if (rx_valid) begin
                    rx_push_req   = 1'b1;
                    cnt_next      = '0;
                    state_next    = ST_WAIT_DONE;
                end else if (cnt_expired) begin
                    timeout_evt   = 1'b1;
                    cnt_next      = '0;
                    state_next    = ST_WAIT_DONE;
                end else begin
                    cnt_next      = cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                // Holding here until the master is idle keeps one byte in flight.
                if (!spi_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                tx_valid_next = 1'b0;
                cnt_next      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rx_empty ? EMPTY_READ_BYTE : rx_head;
            end
        end
    end

    // New events take priority over clr_err so nothing is lost in the clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf      <= 1'b0;
            rx_ovf      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_ovf      <= tx_ovf_evt  || (tx_ovf      && !clr_err);
            rx_ovf      <= rx_ovf_evt  || (rx_ovf      && !clr_err);
            timeout_err <= timeout_evt || (timeout_err && !clr_err);
        end
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb/tb_spi_byte_sequencer.sv - directed and randomized bench with a queue-based reference model
module tb_spi_byte_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;
    localparam int LW    = $clog2(DEPTH) + 1;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_RX   = 2;
    localparam int P_DONE = 3;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [7:0]    wr_data  = '0;
    logic          wr_valid = 1'b0;
    logic          rd_req   = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [7:0]    rx_data  = '0;
    logic          rx_valid = 1'b0;
    logic          spi_busy = 1'b0;
    logic          clr_err  = 1'b0;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          timeout_err;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spi_byte_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .spi_busy    (spi_busy),
        .clr_err     (clr_err),
        .tx_ovf      (tx_ovf),
        .rx_ovf      (rx_ovf),
        .timeout_err (timeout_err),
        .tx_level    (tx_level),
        .rx_level    (rx_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: two byte queues, the transfer phase and cycles spent in it.
    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    int         m_phase    = P_IDLE;
    int         m_age      = 0;
    logic       m_tx_valid = 1'b0;
    logic [7:0] m_tx_data  = '0;
    logic       m_rd_valid = 1'b0;
    logic [7:0] m_rd_data  = '0;
    logic       m_tx_ovf   = 1'b0;
    logic       m_rx_ovf   = 1'b0;
    logic       m_tmo      = 1'b0;

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_phase    = P_IDLE;
        m_age      = 0;
        m_tx_valid = 1'b0;
        m_tx_data  = '0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
        m_tx_ovf   = 1'b0;
        m_rx_ovf   = 1'b0;
        m_tmo      = 1'b0;
    endtask

    task automatic model_step();
        bit tx_was_full = (m_txq.size() == DEPTH);
        bit tx_ovf_e    = 1'b0;
        bit rx_ovf_e    = 1'b0;
        bit tmo_e       = 1'b0;
        // Host read sees the rx queue before any reply byte lands this cycle.
        m_rd_valid = rd_req;
        if (rd_req) begin
            if (m_rxq.size() > 0) m_rd_data = m_rxq.pop_front();
            else                  m_rd_data = 8'hFF;
        end
        case (m_phase)
            P_IDLE: begin
                if (m_txq.size() > 0 && !spi_busy) begin
                    m_tx_data  = m_txq.pop_front();
                    m_tx_valid = 1'b1;
                    m_phase    = P_REQ;
                    m_age      = 0;
                end
            end
            P_REQ: begin
                if (tx_ready) begin
                    m_tx_valid = 1'b0;
                    m_phase    = P_RX;
                    m_age      = 0;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        tmo_e      = 1'b1;
                        m_tx_valid = 1'b0;
                        m_phase    = P_DONE;
                    end
                end
            end
            P_RX: begin
                if (rx_valid) begin
                    if (m_rxq.size() < DEPTH) m_rxq.push_back(rx_data);
                    else                      rx_ovf_e = 1'b1;
                    m_phase = P_DONE;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        tmo_e   = 1'b1;
                        m_phase = P_DONE;
                    end
                end
            end
            default: begin
                if (!spi_busy) m_phase = P_IDLE;
            end
        endcase
        if (wr_valid) begin
            if (tx_was_full) tx_ovf_e = 1'b1;
            else             m_txq.push_back(wr_data);
        end
        m_tx_ovf = tx_ovf_e || (m_tx_ovf && !clr_err);
        m_rx_ovf = rx_ovf_e || (m_rx_ovf && !clr_err);
        m_tmo    = tmo_e    || (m_tmo    && !clr_err);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("tx_valid", 32'(tx_valid), 32'(m_tx_valid));
            if (m_tx_valid) check("tx_data", 32'(tx_data), 32'(m_tx_data));
            check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            if (m_rd_valid) check("rd_data", 32'(rd_data), 32'(m_rd_data));
            check("tx_level", 32'(tx_level), 32'(m_txq.size()));
            check("rx_level", 32'(rx_level), 32'(m_rxq.size()));
            check("tx_ovf", 32'(tx_ovf), 32'(m_tx_ovf));
            check("rx_ovf", 32'(rx_ovf), 32'(m_rx_ovf));
            check("timeout_err", 32'(timeout_err), 32'(m_tmo));
        end
    end

    logic [7:0] dut_sent[$];
    logic [7:0] last_rd       = '0;
    logic       last_rd_valid = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic wait_tx_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_tx_valid: tx_valid stayed 0 for 40 cycles, expected 1");
        end
    endtask

    // One complete SPI transfer: accept after two cycles, reply, then go idle.
    task automatic serve(input logic [7:0] rxb, input bit pop_with_rx);
        bit ok;
        wait_tx_valid(ok);
        if (ok) begin
            dut_sent.push_back(tx_data);
            tick();
            tick();
            tx_ready = 1'b1;
            spi_busy = 1'b1;
            tick();
            tick();
            rx_valid = 1'b1;
            rx_data  = rxb;
            rd_req   = pop_with_rx;
            tick();
            last_rd       = rd_data;
            last_rd_valid = rd_valid;
            spi_busy      = 1'b0;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bit   ok;
        int   n;
        int   rs;
        int   dly;
        bit   noresp;

        tick();
        tick();
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset tx_level", 32'(tx_level), 32'd0);
        check("reset rx_level", 32'(rx_level), 32'd0);
        check("reset flags", 32'({tx_ovf, rx_ovf, timeout_err}), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Single byte round trip.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        tick();
        serve(8'h3C, 1'b0);
        check("basic tx byte", 32'(dut_sent.size() > 0 ? dut_sent[0] : 8'h00), 32'hA5);
        rd_req = 1'b1;
        tick();
        check("basic rd_valid", 32'(rd_valid), 32'd1);
        check("basic rd_data", 32'(rd_data), 32'h3C);
        tick();
        check("rd_valid is a pulse", 32'(rd_valid), 32'd0);

        // Read of an empty rx FIFO.
        rd_req = 1'b1;
        tick();
        check("empty rd_data", 32'(rd_data), 32'hFF);
        check("empty rd_valid", 32'(rd_valid), 32'd1);
        check("empty rx_level", 32'(rx_level), 32'd0);

        // Tx overflow while the master is busy, then in-order drain of four.
        dut_sent.delete();
        spi_busy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h21 + i);
            tick();
        end
        check("ovf tx_level", 32'(tx_level), 32'd4);
        check("ovf tx_ovf", 32'(tx_ovf), 32'd1);
        clr_err = 1'b1;
        tick();
        check("ovf cleared", 32'(tx_ovf), 32'd0);
        spi_busy = 1'b0;
        for (int i = 0; i < 4; i++) serve(8'(8'h10 + i), 1'b0);
        check("sent count", 32'(dut_sent.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_sent.size(); i++)
            check("sent order", 32'(dut_sent[i]), 32'(8'h21 + i));
        check("rx full level", 32'(rx_level), 32'd4);

        // Full rx FIFO: reply and host read in the same cycle.
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        serve(8'h14, 1'b1);
        check("full pop rd_valid", 32'(last_rd_valid), 32'd1);
        check("full pop oldest", 32'(last_rd), 32'h10);
        check("full pop level", 32'(rx_level), 32'd4);
        check("full pop no ovf", 32'(rx_ovf), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h78;
        tick();
        serve(8'h15, 1'b0);
        check("rx overflow flag", 32'(rx_ovf), 32'd1);
        check("rx overflow level", 32'(rx_level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            tick();
            check("rx drain", 32'(rd_data), 32'(8'h11 + i));
        end
        check("rx drained", 32'(rx_level), 32'd0);
        clr_err = 1'b1;
        tick();

        // Master never accepts.
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        tick();
        wait_tx_valid(ok);
        n = 0;
        while (tx_valid && n < 400) begin
            n++;
            tick();
        end
        check("timeout cycles", 32'(n), 32'd255);
        check("timeout flag", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        tick();
        check("timeout cleared", 32'(timeout_err), 32'd0);
        tick();

        // Reset in WAIT_RX with two bytes queued.
        wr_valid = 1'b1;
        wr_data  = 8'h31;
        tick();
        wr_valid = 1'b1;
        wr_data  = 8'h32;
        tick();
        wr_valid = 1'b1;
        wr_data  = 8'h33;
        tick();
        tx_ready = 1'b1;
        spi_busy = 1'b1;
        tick();
        tick();
        check("pre-reset tx_level", 32'(tx_level), 32'd2);
        check("pre-reset tx_data", 32'(tx_data), 32'h31);
        rst = 1'b1;
        #1;
        check("mid reset tx_valid", 32'(tx_valid), 32'd0);
        check("mid reset tx_data", 32'(tx_data), 32'd0);
        check("mid reset rd_data", 32'(rd_data), 32'd0);
        check("mid reset rd_valid", 32'(rd_valid), 32'd0);
        check("mid reset levels", 32'({tx_level, rx_level}), 32'd0);
        check("mid reset flags", 32'({tx_ovf, rx_ovf, timeout_err}), 32'd0);
        tick();
        tick();
        rst      = 1'b0;
        spi_busy = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        tick();
        tick();
        check("late rx ignored", 32'(rx_level), 32'd0);
        check("post reset tx_level", 32'(tx_level), 32'd0);
        check("post reset tx_valid", 32'(tx_valid), 32'd0);

        // Randomized traffic against a reactive SPI master.
        rs     = 0;
        dly    = 0;
        noresp = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            wr_valid = ($urandom_range(0, 99) < 30);
            wr_data  = 8'($urandom);
            rd_req   = ($urandom_range(0, 99) < 20);
            clr_err  = ($urandom_range(0, 99) < 3);
            case (rs)
                0: begin
                    spi_busy = ($urandom_range(0, 99) < 10);
                    if (tx_valid) begin
                        rs       = 1;
                        dly      = $urandom_range(0, 4);
                        noresp   = ($urandom_range(0, 99) < 4);
                        spi_busy = 1'b0;
                    end else if ($urandom_range(0, 99) < 5) begin
                        rx_valid = 1'b1;
                        rx_data  = 8'($urandom);
                    end
                end
                1: begin
                    if (noresp) begin
                        if (!tx_valid) begin
                            rs       = 3;
                            dly      = $urandom_range(0, 3);
                            spi_busy = 1'b1;
                        end
                    end else if (dly == 0) begin
                        tx_ready = 1'b1;
                        spi_busy = 1'b1;
                        if ($urandom_range(0, 99) < 4) begin
                            rs  = 4;
                            dly = TMO + 5;
                        end else begin
                            rs  = 2;
                            dly = $urandom_range(0, 5);
                        end
                    end else begin
                        dly--;
                    end
                    if (!tx_ready && $urandom_range(0, 99) < 5) begin
                        rx_valid = 1'b1;
                        rx_data  = 8'($urandom);
                    end
                end
                2: begin
                    if (dly == 0) begin
                        rx_valid = 1'b1;
                        rx_data  = 8'($urandom);
                        rs       = 3;
                        dly      = $urandom_range(0, 3);
                    end else begin
                        dly--;
                    end
                end
                4: begin
                    if (dly == 0) begin
                        rs  = 3;
                        dly = $urandom_range(0, 3);
                    end else begin
                        dly--;
                    end
                end
                default: begin
                    if (dly == 0) begin
                        spi_busy = 1'b0;
                        rs       = 0;
                    end else begin
                        dly--;
                        if ($urandom_range(0, 99) < 5) begin
                            rx_valid = 1'b1;
                            rx_data  = 8'($urandom);
                        end
                    end
                end
            endcase
            tick();
        end
        spi_busy = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_byte_sequencer.md
SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, entries per byte FIFO; power of two, 2..16.
REQ-002 Parameter: TIMEOUT, default 255, max cycles waiting for spi_master tx_ready or rx_valid.
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_data  in  8  byte written by the I2C slave side.
REQ-006 wr_valid  in  1  one-cycle push strobe for wr_data.
REQ-007 rd_req  in  1  one-cycle pop strobe from the I2C slave side.
REQ-008 rd_data  out  8  popped rx byte.
REQ-009 rd_valid  out  1  one-cycle pulse marking rd_data valid.
REQ-010 tx_data  out  8  byte to spi_master.
REQ-011 tx_valid  out  1  request to spi_master.
REQ-012 tx_ready  in  1  one-cycle acceptance pulse from spi_master.
REQ-013 rx_data  in  8  byte received by spi_master.
REQ-014 rx_valid  in  1  one-cycle pulse from spi_master.
REQ-015 spi_busy  in  1  spi_master busy.
REQ-016 clr_err  in  1  clears sticky flags.
REQ-017 tx_ovf, rx_ovf, timeout_err  out  1 each  sticky error flags.
REQ-018 tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1 each  FIFO occupancy.

Function
REQ-019 Tx FIFO SHALL push wr_data on wr_valid when not full; when full, the byte SHALL be dropped and tx_ovf set, even if a pop occurs the same cycle.
REQ-020 Sequencer states SHALL be IDLE, REQ, WAIT_RX, WAIT_DONE.
REQ-021 IDLE: when tx FIFO non-empty and spi_busy=0, pop the head into tx_data, assert tx_valid next cycle, go to REQ.
REQ-022 REQ: hold tx_valid and tx_data stable; on tx_ready, deassert tx_valid in the same-edge update and go to WAIT_RX.
REQ-023 WAIT_RX: on rx_valid, push rx_data into rx FIFO and go to WAIT_DONE.
REQ-024 WAIT_DONE: on spi_busy=0, go to IDLE; a new byte SHALL NOT start earlier, giving at most one byte in flight.
REQ-025 A TIMEOUT-cycle counter SHALL run in REQ and WAIT_RX and reset on each state entry; on expiry, set timeout_err, deassert tx_valid, discard the byte, and go to WAIT_DONE.
REQ-026 Rx FIFO push when full SHALL drop the byte and set rx_ovf.
REQ-027 rd_req with rx FIFO non-empty SHALL pop, with rd_data valid and rd_valid=1 exactly one cycle later.
REQ-028 rd_req with rx FIFO empty SHALL produce rd_data=8'hFF and rd_valid=1 one cycle later, with no pop and no flag.
REQ-029 Simultaneous rx push and rd_req pop SHALL both take effect; level is unchanged, and a full FIFO is permitted only if the pop is processed first.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be in the range 0..FIFO_DEPTH.
REQ-031 clr_err SHALL clear all sticky flags next cycle; a flag event in the same cycle SHALL win (flag stays set).
REQ-032 rx_valid outside WAIT_RX SHALL be ignored.

Reset
REQ-033 rst SHALL immediately force state IDLE, tx_valid=0, tx_data=0, rd_data=0, rd_valid=0, both FIFOs empty (levels 0), all flags 0, and the timeout counter to 0.
REQ-034 rst mid-transfer SHALL discard all buffered and in-flight bytes; no rx byte from the aborted transfer SHALL be stored after reset release.

Structure
REQ-035 State encodings, the 8'hFF empty-read value and the TIMEOUT default SHALL live in shared package bridge_pkg.
REQ-036 Both FIFOs SHALL be instances of one sub-module byte_fifo (parameter DEPTH, push/pop/full/empty/level).

Verification
REQ-037 Push 8'hA5; spi model pulses tx_ready at cycle 2, returns rx 8'h3C -> tx_data=8'hA5 while tx_valid; rd_req then rd_data=8'h3C with rd_valid one cycle after rd_req.
REQ-038 Push 5 bytes back-to-back with spi_busy=1 and FIFO_DEPTH=4 -> tx_level=4, tx_ovf=1, and only the first 4 bytes are transmitted, in order.
REQ-039 rd_req on empty rx FIFO -> rd_data=8'hFF, rd_valid=1, rx_level stays 0.
REQ-040 tx_ready never arrives -> tx_valid drops after 255 cycles, timeout_err=1; clr_err clears it next cycle.
REQ-041 Assert rst while in WAIT_RX with 2 bytes queued -> all outputs at reset values and levels 0; a late rx_valid after release leaves rx_level=0.
REQ-042 Fill rx FIFO to 4, then issue rx push and rd_req in the same cycle -> level stays 4, no rx_ovf, and the popped byte is the oldest.
